instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Parametrised program counter plus instruction memory with a start/run/halt sequencer and a valid/ready handshake toward the decode stage. Replaces the free-running counter-plus-register-file fetch path of the BIP datapath. Adds a loader write port, jump redirect, back-pressure stall, HALT-opcode detection and a delivered-instruction counter.

Parameters:
N_ADDR, 11, PC / instruction-memory address width; depth is 2**N_ADDR.
N_DATA, 16, instruction width.
N_OPCODE, 5, opcode width; opcode is instr[N_DATA-1 -: N_OPCODE].
HALT_OPCODE, 0, opcode value that stops fetching.
N_CNT, 16, width of the delivered-instruction counter.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; forces IDLE
start  in  1  pulse: begin fetching from address 0
prog_we  in  1  loader write enable
prog_addr  in  N_ADDR  loader write address
prog_data  in  N_DATA  loader write data
jump  in  1  redirect; sampled only on a handshake cycle
jump_addr  in  N_ADDR  redirect target
instr_ready  in  1  decode stage accepts instr this cycle
instr  out  N_DATA  current instruction (memory registered read data)
instr_pc  out  N_ADDR  address of instr
instr_valid  out  1  instr/instr_pc are valid
halted  out  1  HALT state
busy  out  1  FILL or RUN state
instr_count  out  N_CNT  instructions delivered since last start, saturating

Behaviour:
- Reset (async): state=IDLE, instr_pc=0, instr_valid=0, halted=0, busy=0, instr_count=0. Memory contents are NOT reset. instr is undefined until the first read.
- Memory: synchronous read, 1-cycle latency, single write port. rd_addr is a combinational mux. The memory output register IS the instr output; no extra stage.
- fire = instr_valid & instr_ready.
- States:
  - IDLE: instr_valid=0. prog_we writes mem[prog_addr]. start & !prog_we -> FILL with rd_addr=0 and instr_count cleared.
  - FILL (1 cycle): busy=1, valid=0, instr_pc<=0 -> RUN. Next cycle instr=mem[0], instr_valid=1.
  - RUN: busy=1, instr_valid=1.
    - No fire: rd_addr=instr_pc, so the same word is re-read and instr/instr_pc are held stable.
    - Fire and opcode==HALT_OPCODE: -> HALT, instr_valid=0 next cycle. The HALT word itself is delivered and counted. jump is ignored.
    - Fire and jump: rd_addr=jump_addr, instr_pc<=jump_addr. The next cycle presents mem[jump_addr] with zero bubble.
    - Fire otherwise: rd_addr=instr_pc+1, modulo 2**N_ADDR (address 2**N_ADDR-1 wraps to 0).
    - jump without fire is ignored.
  - HALT: halted=1, valid=0, instr_count held. prog_we is accepted. start & !prog_we -> FILL (restart at 0, count cleared).
- Loader priority: prog_we is ignored in FILL and RUN. In IDLE/HALT, prog_we and start in the same cycle perform the write and ignore start.
- instr_count: increments by 1 on each fire and saturates at 2**N_CNT-1.
- Reset mid-RUN: immediate return to IDLE. The in-flight instruction is dropped (valid low asynchronously).
- start in FILL or RUN is ignored.

Decomposition:
- Shared package ifu_pkg holds:
  - the state encoding constants IDLE/FILL/RUN/HALT (2 bits);
  - the default HALT_OPCODE;
  - an opcode-field extraction function.
- One sub-module, ifu_instr_mem: parametrised (N_ADDR, N_DATA) sync-read RAM with one write and one read port. Top level holds the FSM, PC/address mux and counter.

Test Plan:
- Setup for the scenarios below: N_ADDR=11, N_DATA=16, HALT opcode 00000 in bits[15:11].
- Load and run: load mem[0]=16'h0801, mem[1]=16'h1002, mem[2]=16'h0000, instr_ready=1, pulse start -> valid rises 2 cycles after start. instr_pc sequence is 0,1,2 with those words, then halted=1, valid=0, instr_count=3.
- Stall: hold instr_ready=0 for 4 cycles while instr_pc=1 -> instr=16'h1002 and instr_pc=1 stay stable and count is unchanged. Releasing ready gives pc=2 next cycle.
- Jump: at fire with instr_pc=1, assert jump, jump_addr=11'h400 with mem[11'h400]=16'h2000 -> next cycle instr_pc=11'h400, instr=16'h2000, no invalid cycle. jump asserted with ready=0 has no effect.
- Wrap: mem[11'h7FF]=16'h0801, jump to 11'h7FF, fire -> instr_pc=0.
- Loader gating: prog_we to mem[1] during RUN -> mem[1] unchanged after a later restart. prog_we and start together in HALT -> write happens and state stays HALT.
- Async reset mid-RUN at instr_pc=5 -> valid=0, busy=0, instr_pc=0 immediately. Memory contents survive, and a restart delivers mem[0] again.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: sequencer state encoding,
// default HALT opcode and the opcode-field extractor.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } ifu_state_e;

  localparam int unsigned DEFAULT_HALT_OPCODE = 0;

  // Wide enough for any instruction width this unit is built with.
  localparam int unsigned FIELD_W = 64;

  // Returns the top n_opcode bits of an n_data-bit word, right-justified.
  function automatic logic [FIELD_W-1:0] opcode_field(
    input logic [FIELD_W-1:0] word,
    input int unsigned        n_data,
    input int unsigned        n_opcode
  );
    logic [FIELD_W-1:0] mask;
    mask = '1;
    mask = ~(mask << n_opcode);
    return (word >> (n_data - n_opcode)) & mask;
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-to-decode handshake: instruction/PC with valid/ready, plus the
// decode-side jump redirect request.
interface ifu_if #(
  parameter int N_ADDR = 11,
  parameter int N_DATA = 16
);

  logic [N_DATA-1:0] instr;
  logic [N_ADDR-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              jump;
  logic [N_ADDR-1:0] jump_addr;

  modport master (
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  jump,
    input  jump_addr
  );

  modport slave (
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output jump,
    output jump_addr
  );

endinterface

// File: rtl/ifu_instr_mem.sv
// Instruction memory: one write port, one synchronous read port with a
// single-cycle latency. Contents are never reset.
module ifu_instr_mem #(
  parameter int N_ADDR = 11,
  parameter int N_DATA = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [N_ADDR-1:0] wr_addr,
  input  logic [N_DATA-1:0] wr_data,
  input  logic [N_ADDR-1:0] rd_addr,
  output logic [N_DATA-1:0] rd_data
);

  logic [N_DATA-1:0] mem [2**N_ADDR];
  logic [N_DATA-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, instruction memory and start/run/halt sequencer feeding the
// decode stage over a valid/ready handshake.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                  N_ADDR      = 11,
  parameter int                  N_DATA      = 16,
  parameter int                  N_OPCODE    = 5,
  parameter logic [N_OPCODE-1:0] HALT_OPCODE = N_OPCODE'(DEFAULT_HALT_OPCODE),
  parameter int                  N_CNT       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [N_ADDR-1:0] prog_addr,
  input  logic [N_DATA-1:0] prog_data,
  ifu_if.master             fetch,
  output logic              halted,
  output logic              busy,
  output logic [N_CNT-1:0]  instr_count
);

  ifu_state_e        state_q, state_d;
  logic [N_ADDR-1:0] pc_q, pc_d;
  logic [N_CNT-1:0]  cnt_q, cnt_d;

  logic [N_ADDR-1:0] rd_addr;
  logic              mem_we;
  logic              valid;
  logic              fire;
  logic [N_OPCODE-1:0] opcode;

  assign valid  = (state_q == RUN);
  assign fire   = valid & fetch.instr_ready;
  assign opcode = N_OPCODE'(opcode_field(FIELD_W'(fetch.instr), N_DATA, N_OPCODE));

  ifu_instr_mem #(
    .N_ADDR (N_ADDR),
    .N_DATA (N_DATA)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_addr (rd_addr),
    .rd_data (fetch.instr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // The read address always targets the word to be presented next cycle, so
  // a stall simply re-reads the current PC and holds the output stable.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    rd_addr = pc_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE, HALT: begin
        if (prog_we) begin
          mem_we = 1'b1;
        end else if (start) begin
          state_d = FILL;
          rd_addr = '0;
          cnt_d   = '0;
        end
      end

      FILL: begin
        pc_d    = '0;
        rd_addr = '0;
        state_d = RUN;
      end

      RUN: begin
        if (fire) begin
          if (cnt_q != {N_CNT{1'b1}}) begin
            cnt_d = cnt_q + N_CNT'(1);
          end
          if (opcode == HALT_OPCODE) begin
            state_d = HALT;
          end else if (fetch.jump) begin
            rd_addr = fetch.jump_addr;
            pc_d    = fetch.jump_addr;
          end else begin
            rd_addr = pc_q + N_ADDR'(1);
            pc_d    = pc_q + N_ADDR'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fetch.instr_valid = valid;
  assign fetch.instr_pc    = pc_q;
  assign halted            = (state_q == HALT);
  assign busy              = (state_q == FILL) || (state_q == RUN);
  assign instr_count       = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes the expected delivered
// stream from a word-level program model; a negedge monitor pops and compares.
module tb_instr_fetch_unit;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic          halted;
  logic          busy;
  logic [15:0]   instr_count;

  ifu_if #(.N_ADDR(AW), .N_DATA(DW)) fetch ();

  instr_fetch_unit #(
    .N_ADDR      (AW),
    .N_DATA      (DW),
    .N_OPCODE    (5),
    .HALT_OPCODE (5'd0),
    .N_CNT       (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .fetch       (fetch),
    .halted      (halted),
    .busy        (busy),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            isHalt;
    logic [AW-1:0] pc;
    logic [DW-1:0] word;
    int            count;
  } exp_t;

  exp_t          expQ[$];
  logic [DW-1:0] modelMem [2**AW];
  bit            modelRunning = 1'b0;
  logic [AW-1:0] modelPc;
  int            modelCount;
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int satInc(input int c);
    return (c < 65535) ? c + 1 : c;
  endfunction

  // One clock of stimulus. When the model believes the unit is running and
  // ready is offered, the consumed word decides the next expected delivery.
  task automatic applyStimulus(input bit r, input bit j, input logic [AW-1:0] ja, input bit s, input bit we);
    logic [DW-1:0] w;
    exp_t e;
    fetch.instr_ready = r;
    fetch.jump        = j;
    fetch.jump_addr   = ja;
    start             = s;
    prog_we           = we;
    if (modelRunning && r) begin
      w = modelMem[modelPc];
      modelCount = satInc(modelCount);
      if (w[15:11] == 5'd0) begin
        modelRunning = 1'b0;
        e = '{isHalt: 1'b1, pc: modelPc, word: w, count: modelCount};
      end else begin
        modelPc = j ? ja : AW'(modelPc + 1);
        e = '{isHalt: 1'b0, pc: modelPc, word: modelMem[modelPc], count: modelCount};
      end
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    prog_we = 1'b0;
  endtask

  task automatic loadWord(input logic [AW-1:0] a, input logic [DW-1:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    modelMem[a] = d;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
  endtask

  task automatic startRun();
    exp_t e;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("fill_busy", {31'd0, busy}, 32'd1);
    checkOutput("fill_valid", {31'd0, fetch.instr_valid}, 32'd0);
    @(posedge clk);
    #1;
    modelPc      = '0;
    modelCount   = 0;
    modelRunning = 1'b1;
    e = '{isHalt: 1'b0, pc: '0, word: modelMem[0], count: 0};
    expQ.push_back(e);
  endtask

  task automatic stopByReset();
    modelRunning = 1'b0;
    expQ.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic runUntilHalt(input bit randomMode, input int budget, input bit timeoutIsError);
    int n;
    bit wasRunning;
    n = 0;
    while ((modelRunning || expQ.size() != 0) && n < budget) begin
      wasRunning = modelRunning;
      if (randomMode) begin
        prog_addr = AW'($urandom_range(0, 2**AW - 1));
        prog_data = DW'($urandom_range(0, 65535));
        applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
                      AW'($urandom_range(0, 2**AW - 1)),
                      wasRunning && ($urandom_range(0, 15) == 0),
                      wasRunning && ($urandom_range(0, 15) == 0));
      end else begin
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
      end
      n++;
    end
    if (modelRunning || expQ.size() != 0) begin
      if (timeoutIsError) begin
        checkOutput("halt_timeout", 32'(n), 32'(budget + 1));
      end
      stopByReset();
    end
  endtask

  // Monitor: compares the presented instruction against the queue head and
  // pops on each handshake; a halt marker is checked on the cycle after.
  always @(negedge clk) begin
    exp_t cur;
    if (expQ.size() == 0) begin
      if (fetch.instr_valid !== 1'b0) begin
        checkOutput("unexpected_valid", {31'd0, fetch.instr_valid}, 32'd0);
      end
    end else begin
      cur = expQ[0];
      if (cur.isHalt) begin
        checkOutput("halt_valid", {31'd0, fetch.instr_valid}, 32'd0);
        checkOutput("halt_halted", {31'd0, halted}, 32'd1);
        checkOutput("halt_busy", {31'd0, busy}, 32'd0);
        checkOutput("halt_count", {16'd0, instr_count}, 32'(cur.count));
        void'(expQ.pop_front());
      end else begin
        checkOutput("valid", {31'd0, fetch.instr_valid}, 32'd1);
        checkOutput("instr_pc", 32'(fetch.instr_pc), 32'(cur.pc));
        checkOutput("instr", 32'(fetch.instr), 32'(cur.word));
        checkOutput("count", {16'd0, instr_count}, 32'(cur.count));
        if (fetch.instr_valid && fetch.instr_ready) begin
          void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    fetch.instr_ready = 1'b0;
    fetch.jump = 1'b0;
    fetch.jump_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, fetch.instr_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_halted", {31'd0, halted}, 32'd0);
    checkOutput("rst_pc", 32'(fetch.instr_pc), 32'd0);
    checkOutput("rst_count", {16'd0, instr_count}, 32'd0);
    reset = 1'b0;

    for (int a = 0; a < 2**AW; a++) begin
      loadWord(AW'(a), DW'($urandom_range(0, 65535)));
    end
    loadWord(11'h000, 16'h0801);
    loadWord(11'h001, 16'h1002);
    loadWord(11'h002, 16'h0000);
    loadWord(11'h003, 16'h0803);
    loadWord(11'h004, 16'h0804);
    loadWord(11'h005, 16'h0805);
    loadWord(11'h006, 16'h0000);
    loadWord(11'h400, 16'h2000);
    loadWord(11'h7FF, 16'h0801);

    // Straight run 0,1,2 then halt with three delivered.
    fetch.instr_ready = 1'b1;
    startRun();
    runUntilHalt(1'b0, 20, 1'b1);

    // Stall at pc 1 for four cycles.
    startRun();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("stall_count", {16'd0, instr_count}, 32'd1);
    runUntilHalt(1'b0, 20, 1'b1);

    // Jump ignored without ready, taken with it, then wrap from the top address.
    startRun();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 11'h400, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 11'h400, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 11'h7FF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    runUntilHalt(1'b0, 20, 1'b1);

    // Loader write during RUN must be dropped.
    startRun();
    prog_addr = 11'h001;
    prog_data = 16'hFFFF;
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
    runUntilHalt(1'b0, 20, 1'b1);

    // Write and start together in HALT: write wins, unit stays halted.
    prog_we = 1'b1;
    start = 1'b1;
    prog_addr = 11'h002;
    prog_data = 16'h3000;
    modelMem[2] = 16'h3000;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    start = 1'b0;
    checkOutput("we_start_halted", {31'd0, halted}, 32'd1);
    checkOutput("we_start_busy", {31'd0, busy}, 32'd0);
    startRun();
    runUntilHalt(1'b0, 20, 1'b1);

    // Asynchronous reset with pc 5 on the bus.
    startRun();
    repeat (5) applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    modelRunning = 1'b0;
    expQ.delete();
    reset = 1'b1;
    #1;
    checkOutput("arst_valid", {31'd0, fetch.instr_valid}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_pc", 32'(fetch.instr_pc), 32'd0);
    checkOutput("arst_count", {16'd0, instr_count}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    startRun();
    runUntilHalt(1'b0, 20, 1'b1);

    // Randomised runs: ready, jumps, stray start/prog_we while running.
    for (int r = 0; r < 10; r++) begin
      startRun();
      runUntilHalt(1'b1, 300, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
